// File: rtl/kernel_feed.sv
// Kernel feeder: fetches one kernel word per LOAD, replays it (reuse_end+1) beats to the
// MAC array, and walks (word_end+1) words per layer. Optional macro: KERNEL_FEED_MASK_EN.
module kernel_feed #(
  parameter int CFG_DWIDTH    = 32,
  parameter int CFG_AWIDTH    = 5,
  parameter int CFG_FEED_ADDR = 10,
  parameter int GROUP_NB      = 4,
  parameter int KER_WIDTH     = 16,
  parameter int DEPTH_NB      = 16,
  parameter int MEM_LAT       = 2,
  localparam int W            = GROUP_NB*KER_WIDTH*DEPTH_NB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_data,
  input  logic [CFG_AWIDTH-1:0] cfg_addr,
  input  logic                  cfg_valid,
  input  logic [W-1:0]          kernel_bus,
  output logic                  kernel_rdy,
  output logic [W-1:0]          ker_data,
  output logic                  ker_val,
  input  logic                  ker_rdy,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  typedef struct packed {
    logic [15:0] word_end;
    logic [15:0] reuse_end;
  } layer_cfg_t;

  state_e     state_q, state_d;
  layer_cfg_t cfg_q, cfg_d;
  logic [15:0] word_q, word_d;
  logic [15:0] reuse_q, reuse_d;
  logic [3:0]  lat_q, lat_d;
  logic [W-1:0] data_q, data_d;
  logic        krdy_q, krdy_d;

  logic cfg_hit;
  logic lat_last;

  assign cfg_hit  = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_FEED_ADDR));
  assign lat_last = (lat_q == 4'(MEM_LAT-1));

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    word_d  = word_q;
    reuse_d = reuse_q;
    lat_d   = lat_q;
    data_d  = data_q;
    krdy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_hit) begin
          cfg_d   = layer_cfg_t'(cfg_data[31:0]);
          word_d  = '0;
          reuse_d = '0;
          lat_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The upstream word is only trusted on the last latency cycle.
        if (lat_last) begin
          data_d  = kernel_bus;
          state_d = RUN;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      RUN: begin
        if (ker_rdy) begin
          if (reuse_q == cfg_q.reuse_end) begin
            if (word_q == cfg_q.word_end) begin
              state_d = DONE;
            end else begin
              word_d  = word_q + 16'd1;
              reuse_d = '0;
              lat_d   = '0;
              krdy_d  = 1'b1;
              state_d = LOAD;
            end
          end else begin
            reuse_d = reuse_q + 16'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      word_q  <= '0;
      reuse_q <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      krdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      word_q  <= word_d;
      reuse_q <= reuse_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      krdy_q  <= krdy_d;
    end
  end

  assign kernel_rdy = krdy_q;
  assign ker_val    = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

`ifdef KERNEL_FEED_MASK_EN
  assign ker_data = ker_val ? data_q : '0;
`else
  assign ker_data = data_q;
`endif

endmodule

// File: tb/tb_kernel_feed.sv
// Randomized bench for kernel_feed: a layer-level model (word list replayed per reuse count)
// is compared against beats, kernel_rdy pulses, load gaps and idle-time ker_data.
module tb_kernel_feed;
  localparam int W       = 4*16*16;
  localparam int MEM_LAT = 2;
  localparam int FEED    = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  cfg_data = '0;
  logic [4:0]   cfg_addr = '0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] kernel_bus = '0;
  logic         kernel_rdy;
  logic [W-1:0] ker_data;
  logic         ker_val;
  logic         ker_rdy = 1'b0;
  logic         busy;
  logic         done;

  kernel_feed #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .kernel_bus(kernel_bus), .kernel_rdy(kernel_rdy), .ker_data(ker_data), .ker_val(ker_val),
    .ker_rdy(ker_rdy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] words[$];
  logic [W-1:0] obs[$];
  logic [W-1:0] exp_q[$];
  int           gaps[$];
  int           n_rdy, n_done, n_bad_rdy, n_bad_hold, n_bad_stab;
  bit           timed_out;
  logic [W-1:0] hold_exp = '0;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Expected beat stream: each word repeated reuse_end+1 times, in order.
  task automatic model_layer(input int re, input int we);
    exp_q.delete();
    for (int w = 0; w <= we; w++)
      for (int r = 0; r <= re; r++) exp_q.push_back(words[w]);
  endtask

  task automatic run_layer(input int re, input int we, input int rdy_pct,
                           input bit inject_cfg, input int abort_after);
    int idx; int gap; bit prev_val; logic [W-1:0] prev_data; bit injected; bit finished;
    words.delete(); obs.delete(); gaps.delete();
    for (int w = 0; w <= we; w++) words.push_back(rand_word());
    n_rdy = 0; n_done = 0; n_bad_rdy = 0; n_bad_hold = 0; n_bad_stab = 0;
    idx = 0; gap = 0; prev_val = 0; prev_data = '0; injected = 0; finished = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      cfg_addr  = 5'(FEED);
      cfg_valid = (cyc == 0);
      cfg_data  = {16'(we), 16'(re)};
      if (inject_cfg && prev_val && !injected) begin
        cfg_valid = 1'b1;
        cfg_data  = {16'(we), 16'(re + 3)};
        injected  = 1;
      end
      kernel_bus = (idx < words.size()) ? words[idx] : rand_word();
      ker_rdy    = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (kernel_rdy) begin
        n_rdy++;
        if (!busy || done || obs.size() == 0) n_bad_rdy++;
        idx++;
      end
      if (ker_val) begin
        if (prev_val && ker_data !== prev_data) n_bad_stab++;
        if (gap > 0) gaps.push_back(gap);
        gap = 0;
        hold_exp = ker_data;
        if (ker_rdy) obs.push_back(ker_data);
      end else begin
        if (busy && !done) gap++;
`ifdef KERNEL_FEED_MASK_EN
        if (ker_data !== '0) n_bad_hold++;
`else
        if (ker_data !== hold_exp) n_bad_hold++;
`endif
      end
      prev_val  = ker_val;
      prev_data = ker_data;
      if (done) begin n_done++; finished = 1; break; end
      if (abort_after > 0 && obs.size() >= abort_after) break;
    end
    cfg_valid = 1'b0;
    ker_rdy   = 1'b0;
    timed_out = !finished && abort_after == 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (ker_val !== 1'b0) begin n_fail++; $display("FAIL reset_ker_val got=%b want=0", ker_val); end
    n_checks++; if (kernel_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_kernel_rdy got=%b want=0", kernel_rdy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (ker_data !== '0) begin n_fail++; $display("FAIL reset_ker_data got=%h want=0", ker_data[63:0]); end
    hold_exp = '0;
    #1 rst = 1'b0;
    // Writes to a different address must not start a layer.
    @(posedge clk); #1; cfg_addr = 5'(FEED + 1); cfg_data = 32'h0001_0001; cfg_valid = 1'b1;
    @(posedge clk); #1; cfg_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL addr_decode_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    run_layer(2, 1, 100, 0, 0);
    model_layer(2, 1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got=1 want=0"); end
    n_checks++; if (obs.size() != 6) begin n_fail++; $display("FAIL basic_beats got=%0d want=6", obs.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_data[%0d] got=%h want=%h", i, obs[i][63:0], exp_q[i][63:0]); end
    end
    n_checks++; if (n_rdy != 1) begin n_fail++; $display("FAIL basic_kernel_rdy got=%0d want=1", n_rdy); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL basic_done got=%0d want=1", n_done); end
    n_checks++; if (n_bad_rdy != 0) begin n_fail++; $display("FAIL basic_rdy_placement got=%0d want=0", n_bad_rdy); end
    n_checks++; if (n_bad_hold != 0) begin n_fail++; $display("FAIL basic_idle_data got=%0d want=0", n_bad_hold); end
  endtask

  task automatic test_single_beat_words();
    run_layer(0, 3, 100, 0, 0);
    model_layer(0, 3);
    n_checks++; if (obs.size() != 4) begin n_fail++; $display("FAIL sbw_beats got=%0d want=4", obs.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL sbw_data[%0d] got=%h want=%h", i, obs[i][63:0], exp_q[i][63:0]); end
    end
    n_checks++; if (n_rdy != 3) begin n_fail++; $display("FAIL sbw_kernel_rdy got=%0d want=3", n_rdy); end
    n_checks++; if (gaps.size() != 4) begin n_fail++; $display("FAIL sbw_gap_count got=%0d want=4", gaps.size()); end
    foreach (gaps[i]) begin
      n_checks++;
      if (gaps[i] != MEM_LAT) begin n_fail++; $display("FAIL sbw_gap[%0d] got=%0d want=%0d", i, gaps[i], MEM_LAT); end
    end
  endtask

  task automatic test_stall();
    for (int t = 0; t < 5; t++) begin
      int re; int we;
      re = (t == 0) ? 3 : $urandom_range(0, 4);
      we = (t == 0) ? 2 : $urandom_range(0, 3);
      run_layer(re, we, 45, 0, 0);
      model_layer(re, we);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout[%0d] got=1 want=0", t); end
      n_checks++;
      if (obs.size() != (re+1)*(we+1)) begin n_fail++; $display("FAIL stall_beats[%0d] got=%0d want=%0d", t, obs.size(), (re+1)*(we+1)); end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_data[%0d][%0d] got=%h want=%h", t, i, obs[i][63:0], exp_q[i][63:0]); end
      end
      n_checks++; if (n_rdy != we) begin n_fail++; $display("FAIL stall_kernel_rdy[%0d] got=%0d want=%0d", t, n_rdy, we); end
      n_checks++; if (n_bad_stab != 0) begin n_fail++; $display("FAIL stall_stable[%0d] got=%0d want=0", t, n_bad_stab); end
      n_checks++; if (n_bad_hold != 0) begin n_fail++; $display("FAIL stall_idle_data[%0d] got=%0d want=0", t, n_bad_hold); end
      foreach (gaps[i]) begin
        n_checks++;
        if (gaps[i] != MEM_LAT) begin n_fail++; $display("FAIL stall_gap[%0d][%0d] got=%0d want=%0d", t, i, gaps[i], MEM_LAT); end
      end
    end
  endtask

  task automatic test_cfg_ignored();
    run_layer(2, 1, 100, 1, 0);
    model_layer(2, 1);
    n_checks++; if (obs.size() != 6) begin n_fail++; $display("FAIL cfgign_beats got=%0d want=6", obs.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL cfgign_data[%0d] got=%h want=%h", i, obs[i][63:0], exp_q[i][63:0]); end
    end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL cfgign_done got=%0d want=1", n_done); end
  endtask

  task automatic test_reset_mid_run();
    run_layer(3, 2, 100, 0, 4);
    @(posedge clk); #1; rst = 1'b1; ker_rdy = 1'b1;
    @(posedge clk); #1; rst = 1'b0; ker_rdy = 1'b0;
    hold_exp = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_checks++; if (ker_val !== 1'b0) begin n_fail++; $display("FAIL midrst_ker_val got=%b want=0", ker_val); end
    n_checks++; if (kernel_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_kernel_rdy got=%b want=0", kernel_rdy); end
    n_checks++; if (ker_data !== '0) begin n_fail++; $display("FAIL midrst_ker_data got=%h want=0", ker_data[63:0]); end
    run_layer(1, 1, 70, 0, 0);
    model_layer(1, 1);
    n_checks++; if (obs.size() != 4) begin n_fail++; $display("FAIL midrst_rerun_beats got=%0d want=4", obs.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_rerun_data[%0d] got=%h want=%h", i, obs[i][63:0], exp_q[i][63:0]); end
    end
    n_checks++; if (n_rdy != 1) begin n_fail++; $display("FAIL midrst_rerun_kernel_rdy got=%0d want=1", n_rdy); end
    n_checks++; if (n_bad_hold != 0) begin n_fail++; $display("FAIL midrst_rerun_idle_data got=%0d want=0", n_bad_hold); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_beat_words();
    test_stall();
    test_cfg_ignored();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
